// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt controller: register map,
// FSM encoding and cause field geometry.
package irq_pkg;

    localparam logic [1:0] IRQ_CAUSE = 2'd0;
    localparam logic [1:0] IRQ_PEND  = 2'd1;
    localparam logic [1:0] IRQ_MASK  = 2'd2;
    localparam logic [1:0] IRQ_CTRL  = 2'd3;

    localparam int IDX_W   = 4;
    localparam int CAUSE_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index plus an any-set flag.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set bit is the last assignment to stick.
    always_comb begin
        idx_o = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: edge-latched sources, mask and global enable, a
// REQ/SVC handshake against PC31, and a small word-addressed register port.
module irq_ctl
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SRC-1:0]   irq_src,
    input  logic               PC31,
    input  logic [1:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    input  logic               re,
    output logic [31:0]        rdata,
    output logic               irq,
    output logic [CAUSE_W-1:0] cause
);

    logic [N_SRC-1:0]   src_q;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic               ge_q, ge_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    irq_state_t         state_q, state_d;

    logic [N_SRC-1:0]   edge_w;
    logic [N_SRC-1:0]   w1c_w;
    logic [N_SRC-1:0]   active_w;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    logic               unused_wdata;
    assign unused_wdata = ^wdata[31:N_SRC];

    assign edge_w   = irq_src & ~src_q;
    assign w1c_w    = (we && addr == IRQ_PEND) ? wdata[N_SRC-1:0] : '0;
    assign active_w = pending_q & mask_q;

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio (
        .req_i (active_w),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // A new edge wins over a same-cycle clear so no request is ever lost.
    always_comb begin
        pending_d = (pending_q & ~w1c_w) | edge_w;
        mask_d    = mask_q;
        ge_d      = ge_q;
        if (we && addr == IRQ_MASK) begin
            mask_d = wdata[N_SRC-1:0];
        end
        if (we && addr == IRQ_CTRL) begin
            ge_d = wdata[0];
        end
    end

    // Reads sample the pre-write register values, so read+write returns old data.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            unique case (addr)
                IRQ_CAUSE: rdata_d = 32'(cause_q);
                IRQ_PEND:  rdata_d = 32'(pending_q);
                IRQ_MASK:  rdata_d = 32'(mask_q);
                IRQ_CTRL:  rdata_d = {31'b0, ge_q};
                default:   rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        irq     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ge_q && win_any) begin
                    cause_d = {1'b1, win_idx};
                    state_d = REQ;
                end
            end
            REQ: begin
                irq = 1'b1;
                if (PC31) begin
                    state_d = SVC;
                end else if (!ge_q) begin
                    state_d            = IDLE;
                    cause_d[CAUSE_W-1] = 1'b0;
                end
            end
            SVC: begin
                if (!PC31) begin
                    state_d            = IDLE;
                    cause_d[CAUSE_W-1] = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
            ge_q      <= 1'b0;
            rdata_q   <= '0;
            cause_q   <= '0;
            state_q   <= IDLE;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ge_q      <= ge_d;
            rdata_q   <= rdata_d;
            cause_q   <= cause_d;
            state_q   <= state_d;
        end
    end

    assign rdata = rdata_q;
    assign cause = cause_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: one task per scenario, inline checks against
// hand-computed values, one line printed per transaction.
module tb_irq_ctl;

    localparam int N_SRC = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_SRC-1:0] irq_src;
    logic             PC31;
    logic [1:0]       addr;
    logic [31:0]      wdata;
    logic             we;
    logic             re;
    logic [31:0]      rdata;
    logic             irq;
    logic [4:0]       cause;

    int n_checks = 0;
    int n_pass   = 0;

    irq_ctl #(.N_SRC(N_SRC)) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .PC31    (PC31),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .irq     (irq),
        .cause   (cause)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        $display("WR  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        tick();
        re   = 1'b0;
        d    = rdata;
        $display("RD  addr=%0d data=0x%08h", a, d);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        irq_src = '0;
        PC31    = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        addr    = '0;
        wdata   = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_checks++;
        if ({irq, cause, rdata} !== 38'd0)
            $display("FAIL reset_outputs irq=%b cause=%b rdata=0x%08h expected all 0", irq, cause, rdata);
        else n_pass++;
        // Drive into REQ with pending = 0x05, then reset mid-request.
        wr(2'd2, 32'hFF);
        wr(2'd3, 32'h1);
        irq_src = 8'h05;
        tick();
        irq_src = 8'h00;
        tick();
        n_checks++;
        if (irq !== 1'b1) $display("FAIL reset_pre_req irq=%b expected 1", irq);
        else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("RST mid-request");
        n_checks++;
        if (irq !== 1'b0 || cause !== 5'd0)
            $display("FAIL reset_mid irq=%b cause=%b expected 0 00000", irq, cause);
        else n_pass++;
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_pending got 0x%08h expected 0x00000000", d);
        else n_pass++;
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL reset_mask got 0x%08h expected 0x00000000", d);
        else n_pass++;
    endtask

    task automatic test_regs();
        logic [31:0] d;
        do_reset();
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'h0000_00FF) $display("FAIL mask_upper got 0x%08h expected 0x000000ff", d);
        else n_pass++;
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, d);
        n_checks++;
        if (d !== 32'h1) $display("FAIL ctrl_rw got 0x%08h expected 0x00000001", d);
        else n_pass++;
        wr(2'd3, 32'h0);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL cause_ro got 0x%08h expected 0x00000000", d);
        else n_pass++;
        wr(2'd2, 32'h0F);
        // Same-cycle read and write returns the old value.
        addr = 2'd2; wdata = 32'hF0; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        $display("RW  addr=2 wdata=0x000000f0 rdata=0x%08h", rdata);
        n_checks++;
        if (rdata !== 32'h0F) $display("FAIL read_write_same got 0x%08h expected 0x0000000f", rdata);
        else n_pass++;
        tick();
        n_checks++;
        if (rdata !== 32'h0F) $display("FAIL rdata_hold got 0x%08h expected 0x0000000f", rdata);
        else n_pass++;
        rd(2'd2, d);
        n_checks++;
        if (d !== 32'hF0) $display("FAIL mask_after_rw got 0x%08h expected 0x000000f0", d);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        do_reset();
        wr(2'd2, 32'h04);
        wr(2'd3, 32'h01);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL basic_lat1 irq=%b expected 0", irq);
        else n_pass++;
        tick();
        $display("TX  basic edge src2 irq=%b cause=%b", irq, cause);
        n_checks++;
        if (irq !== 1'b1 || cause !== 5'b1_0010)
            $display("FAIL basic_req irq=%b cause=%b expected 1 10010", irq, cause);
        else n_pass++;
        PC31 = 1'b1;
        tick();
        n_checks++;
        if (irq !== 1'b0 || cause !== 5'b1_0010)
            $display("FAIL basic_svc irq=%b cause=%b expected 0 10010", irq, cause);
        else n_pass++;
        PC31 = 1'b0;
        tick();
        n_checks++;
        if (irq !== 1'b0 || cause[4] !== 1'b0)
            $display("FAIL basic_ret irq=%b valid=%b expected 0 0", irq, cause[4]);
        else n_pass++;
        tick();
        n_checks++;
        if (irq !== 1'b1) $display("FAIL basic_reraise irq=%b expected 1", irq);
        else n_pass++;
        PC31 = 1'b1;
        tick();
        wr(2'd1, 32'h04);
        PC31 = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (irq !== 1'b0 || cause[4] !== 1'b0)
            $display("FAIL basic_cleared irq=%b valid=%b expected 0 0", irq, cause[4]);
        else n_pass++;
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL basic_pend got 0x%08h expected 0x00000000", d);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        wr(2'd2, 32'hFF);
        wr(2'd3, 32'h01);
        irq_src = 8'h22;
        tick();
        irq_src = 8'h00;
        tick();
        $display("TX  priority edges 5,1 cause=%b", cause);
        n_checks++;
        if (irq !== 1'b1 || cause !== 5'b1_0001)
            $display("FAIL prio_first irq=%b cause=%b expected 1 10001", irq, cause);
        else n_pass++;
        PC31 = 1'b1;
        tick();
        wr(2'd1, 32'h02);
        PC31 = 1'b0;
        tick();
        tick();
        n_checks++;
        if (irq !== 1'b1 || cause !== 5'b1_0101)
            $display("FAIL prio_second irq=%b cause=%b expected 1 10101", irq, cause);
        else n_pass++;
    endtask

    task automatic test_mask_ge();
        logic [31:0] d;
        do_reset();
        wr(2'd3, 32'h01);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        tick();
        n_checks++;
        if (irq !== 1'b0) $display("FAIL masked_noirq irq=%b expected 0", irq);
        else n_pass++;
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h08) $display("FAIL masked_pend got 0x%08h expected 0x00000008", d);
        else n_pass++;
        wr(2'd2, 32'h08);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL unmask_lat irq=%b expected 0", irq);
        else n_pass++;
        tick();
        n_checks++;
        if (irq !== 1'b1 || cause !== 5'b1_0011)
            $display("FAIL unmask_req irq=%b cause=%b expected 1 10011", irq, cause);
        else n_pass++;
        wr(2'd3, 32'h00);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL ge_clear_lat irq=%b expected 1", irq);
        else n_pass++;
        tick();
        n_checks++;
        if (irq !== 1'b0 || cause[4] !== 1'b0)
            $display("FAIL ge_clear irq=%b valid=%b expected 0 0", irq, cause[4]);
        else n_pass++;
    endtask

    task automatic test_clear_race();
        logic [31:0] d;
        do_reset();
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        wr(2'd1, 32'h01);
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h0) $display("FAIL w1c_plain got 0x%08h expected 0x00000000", d);
        else n_pass++;
        irq_src = 8'h01;
        wr(2'd1, 32'h01);
        irq_src = 8'h00;
        rd(2'd1, d);
        n_checks++;
        if (d !== 32'h01) $display("FAIL w1c_race got 0x%08h expected 0x00000001", d);
        else n_pass++;
    endtask

    task automatic test_nested();
        int hi;
        do_reset();
        wr(2'd2, 32'h01);
        wr(2'd3, 32'h01);
        PC31 = 1'b1;
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (irq === 1'b1) hi++;
        end
        $display("TX  nested irq_high_cycles=%0d", hi);
        n_checks++;
        if (hi !== 1) $display("FAIL nested_pulse got %0d cycles expected 1", hi);
        else n_pass++;
        PC31 = 1'b0;
        tick();
        n_checks++;
        if (irq !== 1'b0) $display("FAIL nested_ret irq=%b expected 0", irq);
        else n_pass++;
        tick();
        n_checks++;
        if (irq !== 1'b1 || cause !== 5'b1_0000)
            $display("FAIL nested_reraise irq=%b cause=%b expected 1 10000", irq, cause);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic();
        test_priority();
        test_mask_ge();
        test_clear_race();
        test_nested();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
